// File: rtl/sid_filter_arb_if.sv
// Handshake and data bundle between the SID filter arbiter and its environment.
// slave is the arbiter side; master drives requests, enables and the engine result.
interface sid_filter_arb_if;
    logic        tick;
    logic        en0;
    logic        en1;
    logic [15:0] eng_sound;
    logic        eng_valid;
    logic        eng_sel;
    logic [15:0] sound0;
    logic [15:0] sound1;
    logic        done0;
    logic        done1;
    logic        overrun;

    modport master (
        output tick, en0, en1, eng_sound,
        input  eng_valid, eng_sel, sound0, sound1, done0, done1, overrun
    );

    modport slave (
        input  tick, en0, en1, eng_sound,
        output eng_valid, eng_sel, sound0, sound1, done0, done1, overrun
    );
endinterface

// File: rtl/sid_filter_arb.sv
// Time-shares one filter engine between two SID channels, lowest enabled channel first.
// Latency: eng_valid one cycle after tick; done<ch> LAT+1 cycles after that channel's eng_valid.
// Backpressure: busy-time ticks pulse overrun; SID_FILTER_ARB_TICKQ_EN adds a one-deep tick queue.
module sid_filter_arb #(
    parameter int LAT = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    sid_filter_arb_if.slave  bus
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    pend;
    logic          sel;
    logic [CW-1:0] cnt;
    logic [15:0]   sound0_q;
    logic [15:0]   sound1_q;
    logic          done0_q;
    logic          done1_q;
    logic          ovr_q;
    logic          eng_valid;
    logic          start;
    logic          busy_tick;
    logic          cap_now;
    logic [1:0]    rem;

`ifdef SID_FILTER_ARB_TICKQ_EN
    logic tq;
    assign start = bus.tick | tq;
`else
    assign start = bus.tick;
`endif

    assign busy_tick = bus.tick && (state != IDLE);
    // CAPTURE spans two cycles: sample the engine, then retire the channel.
    assign cap_now   = (state == CAPTURE) && (cnt == CW'(LAT - 1));
    assign rem       = {pend[1] & ~sel, pend[0] & sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (bus.en0 || bus.en1)) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == CW'(LAT - 2)) state_nxt = CAPTURE;
            CAPTURE: if (!cap_now) state_nxt = (rem != 2'b00) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eng_valid = 1'b0;
        if (state == ISSUE) eng_valid = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 2'b00;
            sel      <= 1'b0;
            cnt      <= '0;
            sound0_q <= 16'h0000;
            sound1_q <= 16'h0000;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            if (state == IDLE || state == ISSUE) cnt <= '0;
            else                                 cnt <= cnt + CW'(1);

            if (state == IDLE && start)               pend <= {bus.en1, bus.en0};
            else if (state == CAPTURE && !cap_now)    pend <= rem;

            if (state_nxt == ISSUE) sel <= (state == IDLE) ? ~bus.en0 : ~rem[0];

            if (cap_now && !sel) sound0_q <= bus.eng_sound;
            if (cap_now &&  sel) sound1_q <= bus.eng_sound;
            done0_q <= cap_now & ~sel;
            done1_q <= cap_now &  sel;
        end
    end

`ifdef SID_FILTER_ARB_TICKQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tq    <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (state == IDLE)  tq <= 1'b0;
            else if (busy_tick) tq <= 1'b1;
            ovr_q <= busy_tick & tq;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= 1'b0;
        else        ovr_q <= busy_tick;
    end
`endif

    assign bus.eng_valid = eng_valid;
    assign bus.eng_sel   = sel;
    assign bus.sound0    = sound0_q;
    assign bus.sound1    = sound1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_sid_filter_arb.sv
// Bench for sid_filter_arb: timestamp-based schedule model compared every cycle,
// plus literal cycle expectations for each directed scenario.
module tb_sid_filter_arb;
    localparam int LAT = 13;
    localparam int N   = 1000;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot  = 0;

    sid_filter_arb_if bus ();

    sid_filter_arb #(.LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] snd(input int t);
        return 16'(t * 16'h1357 + 16'h2468);
    endfunction

    always @(posedge clk) begin
        #1;
        bus.eng_sound = snd(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Model: whole passes scheduled as timestamps when a tick is accepted.
    int          busy_end = -1;
    bit          queued   = 1'b0;
    bit          e_valid[N];
    bit          e_d0[N];
    bit          e_d1[N];
    bit          e_ovr[N];
    int          e_sel[N];
    int          cap_ch[N];
    logic [15:0] m_s0 = 16'h0;
    logic [15:0] m_s1 = 16'h0;

    task automatic clear_from(input int t);
        for (int i = t; i < N; i++) begin
            e_valid[i] = 1'b0; e_d0[i] = 1'b0; e_d1[i] = 1'b0;
            e_ovr[i] = 1'b0; e_sel[i] = -1; cap_ch[i] = -1;
        end
    endtask

    task automatic model_step(input int t);
        int n;
        int iss;
        bit go;
        if (!rst_n) begin
            busy_end = -1; queued = 1'b0; m_s0 = 16'h0; m_s1 = 16'h0;
            clear_from(t + 1);
            return;
        end
        if (cap_ch[t] == 0) m_s0 = snd(t);
        if (cap_ch[t] == 1) m_s1 = snd(t);
        if (t > busy_end) begin
            go = bus.tick || queued;
            queued = 1'b0;
            if (go && (bus.en0 || bus.en1)) begin
                n = 0;
                for (int ch = 0; ch < 2; ch++) begin
                    if ((ch == 0) ? bus.en0 : bus.en1) begin
                        iss = t + 1 + n * (LAT + 2);
                        e_valid[iss] = 1'b1;
                        for (int k = iss; k <= iss + LAT + 1; k++) e_sel[k] = ch;
                        cap_ch[iss + LAT] = ch;
                        if (ch == 0) e_d0[iss + LAT + 1] = 1'b1;
                        else         e_d1[iss + LAT + 1] = 1'b1;
                        n++;
                    end
                end
                busy_end = t + n * (LAT + 2);
            end
        end else if (bus.tick) begin
`ifdef SID_FILTER_ARB_TICKQ_EN
            if (queued) e_ovr[t + 1] = 1'b1;
            else        queued = 1'b1;
`else
            e_ovr[t + 1] = 1'b1;
`endif
        end
    endtask

    int vq[$];
    int d0q[$];
    int d1q[$];
    int oq[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_eng_valid", 32'(bus.eng_valid), 0);
            chk("rst_eng_sel",   32'(bus.eng_sel),   0);
            chk("rst_done0",     32'(bus.done0),     0);
            chk("rst_done1",     32'(bus.done1),     0);
            chk("rst_overrun",   32'(bus.overrun),   0);
            chk("rst_sound0",    32'(bus.sound0),    0);
            chk("rst_sound1",    32'(bus.sound1),    0);
        end else begin
            chk("eng_valid", 32'(bus.eng_valid), 32'(e_valid[cyc]));
            chk("done0",     32'(bus.done0),     32'(e_d0[cyc]));
            chk("done1",     32'(bus.done1),     32'(e_d1[cyc]));
            chk("overrun",   32'(bus.overrun),   32'(e_ovr[cyc]));
            if (e_sel[cyc] >= 0) chk("eng_sel", 32'(bus.eng_sel), 32'(e_sel[cyc]));
            chk("sound0",    32'(bus.sound0),    32'(m_s0));
            chk("sound1",    32'(bus.sound1),    32'(m_s1));
        end
        if (bus.eng_valid === 1'b1) vq.push_back(cyc);
        if (bus.done0 === 1'b1)     d0q.push_back(cyc);
        if (bus.done1 === 1'b1)     d1q.push_back(cyc);
        if (bus.overrun === 1'b1)   oq.push_back(cyc);
        model_step(cyc);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        vq.delete(); d0q.delete(); d1q.delete(); oq.delete();
    endtask

    task automatic pulse_tick(output int b);
        b = cyc;
        bus.tick = 1'b1;
        next_cycle();
        bus.tick = 1'b0;
    endtask

    int          b;
    logic [15:0] s0_prev;

    initial begin
        clear_from(0);
        rst_n = 1'b0;
        bus.tick = 1'b0; bus.en0 = 1'b0; bus.en1 = 1'b0; bus.eng_sound = 16'h0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // Both channels: issue at +1 and +16, done at +15 and +30.
        bus.en0 = 1'b1; bus.en1 = 1'b1;
        clear_logs();
        pulse_tick(b);
        repeat (40) next_cycle();
        chk("s1_nvalid", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("s1_valid0_cyc", vq[0] - b, 1);
            chk("s1_valid1_cyc", vq[1] - b, 16);
        end
        chk("s1_ndone0", d0q.size(), 1);
        if (d0q.size() == 1) chk("s1_done0_cyc", d0q[0] - b, 15);
        chk("s1_ndone1", d1q.size(), 1);
        if (d1q.size() == 1) chk("s1_done1_cyc", d1q[0] - b, 30);
        chk("s1_sound0", 32'(bus.sound0), 32'(snd(b + 14)));
        chk("s1_sound1", 32'(bus.sound1), 32'(snd(b + 29)));
        chk("s1_noovr", oq.size(), 0);

        // Channel 1 only.
        s0_prev = bus.sound0;
        bus.en0 = 1'b0; bus.en1 = 1'b1;
        clear_logs();
        pulse_tick(b);
        repeat (40) next_cycle();
        chk("s2_nvalid", vq.size(), 1);
        if (vq.size() == 1) chk("s2_valid_cyc", vq[0] - b, 1);
        chk("s2_ndone0", d0q.size(), 0);
        if (d1q.size() == 1) chk("s2_done1_cyc", d1q[0] - b, 15);
        else                 chk("s2_ndone1", d1q.size(), 1);
        chk("s2_sound0_held", 32'(bus.sound0), 32'(s0_prev));
        chk("s2_sound1", 32'(bus.sound1), 32'(snd(b + 14)));

        // Nothing enabled.
        bus.en0 = 1'b0; bus.en1 = 1'b0;
        clear_logs();
        pulse_tick(b);
        repeat (40) next_cycle();
        chk("s3_nvalid", vq.size(), 0);
        chk("s3_ndone",  d0q.size() + d1q.size(), 0);
        chk("s3_novr",   oq.size(), 0);

        // Busy-time ticks at +5 and +7.
        bus.en0 = 1'b1; bus.en1 = 1'b0;
        clear_logs();
        pulse_tick(b);
        repeat (4) next_cycle();
        bus.tick = 1'b1; next_cycle(); bus.tick = 1'b0; next_cycle();
        bus.tick = 1'b1; next_cycle(); bus.tick = 1'b0;
        repeat (40) next_cycle();
`ifdef SID_FILTER_ARB_TICKQ_EN
        chk("s4_novr", oq.size(), 1);
        if (oq.size() == 1) chk("s4_ovr_cyc", oq[0] - b, 8);
        chk("s4_nvalid", vq.size(), 2);
        if (vq.size() == 2) chk("s4_valid1_cyc", vq[1] - b, 17);
`else
        chk("s4_novr", oq.size(), 2);
        if (oq.size() == 2) begin
            chk("s4_ovr0_cyc", oq[0] - b, 6);
            chk("s4_ovr1_cyc", oq[1] - b, 8);
        end
        chk("s4_nvalid", vq.size(), 1);
`endif

        // Reset at cycle 8 of a pass.
        bus.en0 = 1'b1; bus.en1 = 1'b1;
        clear_logs();
        pulse_tick(b);
        repeat (7) next_cycle();
        rst_n = 1'b0;
        #1;
        chk("s5_sound0_async", 32'(bus.sound0), 0);
        chk("s5_valid_async",  32'(bus.eng_valid), 0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (10) next_cycle();
        chk("s5_ndone_abort", d0q.size() + d1q.size(), 0);
        chk("s5_nvalid_abort", vq.size(), 1);
        clear_logs();
        pulse_tick(b);
        repeat (36) next_cycle();
        chk("s5_nvalid", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("s5_valid0_cyc", vq[0] - b, 1);
            chk("s5_valid1_cyc", vq[1] - b, 16);
        end
        if (d1q.size() == 1) chk("s5_done1_cyc", d1q[0] - b, 30);
        else                 chk("s5_ndone1", d1q.size(), 1);

        // en1 dropped after the tick: channel 1 still served.
        clear_logs();
        pulse_tick(b);
        bus.en1 = 1'b0;
        repeat (40) next_cycle();
        chk("s6_nvalid", vq.size(), 2);
        if (d1q.size() == 1) chk("s6_done1_cyc", d1q[0] - b, 30);
        else                 chk("s6_ndone1", d1q.size(), 1);
        chk("s6_sound1", 32'(bus.sound1), 32'(snd(b + 29)));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
